// File: rtl/gf_sram_fifo.sv
// Ready/valid FIFO built on byte-lane GF_SRAM_512x8 macros with a 2-entry output buffer.
// The empty path bypasses the SRAM; the SRAM is single-port and reads take priority.
module gf_sram_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 512
) (
   input  logic                         clk,
   input  logic                         resetn,
   input  logic                         flush,
   input  logic [WIDTH-1:0]             in_data,
   input  logic                         in_valid,
   output logic                         in_ready,
   output logic [WIDTH-1:0]             out_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [$clog2(DEPTH+3)-1:0]   count
);

   localparam int AW    = $clog2(DEPTH);
   localparam int SCW   = $clog2(DEPTH+1);
   localparam int CW    = $clog2(DEPTH+3);
   localparam int LANES = WIDTH/8;
   localparam logic [SCW-1:0] DEPTH_C = SCW'(DEPTH);

   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [SCW-1:0]   sram_cnt;
   logic             rd_inflight;
   logic [1:0]       ob_cnt;
   logic [WIDTH-1:0] ob0, ob1;

   logic             run, rd_sel, do_read, bypass_mode, write_mode;
   logic             push, pop, wr_go, byp_go, load;
   logic [1:0]       ob_occ, cnt_after_pop, ob_cnt_n;
   logic [WIDTH-1:0] ob0_n, ob1_n, load_data, q;

   logic             sram_cen, sram_gwen;
   logic [9:0]       sram_a;

   // The operation for this cycle is chosen from registered state only.
   assign run         = resetn && !flush;
   assign ob_occ      = ob_cnt + {1'b0, rd_inflight};
   assign rd_sel      = (sram_cnt != '0) && (ob_occ < 2'd2);
   assign do_read     = run && rd_sel;
   assign bypass_mode = (sram_cnt == '0) && !rd_inflight && (ob_cnt < 2'd2);
   assign write_mode  = !rd_sel && !bypass_mode && (sram_cnt < DEPTH_C);

   assign in_ready  = run && (bypass_mode || write_mode);
   assign push      = in_valid && in_ready;
   assign wr_go     = push && write_mode;
   assign byp_go    = push && bypass_mode;
   assign out_valid = (ob_cnt != 2'd0);
   assign out_data  = ob0;
   assign pop       = out_valid && out_ready;
   assign count     = CW'(sram_cnt) + CW'(rd_inflight) + CW'(ob_cnt);

   assign sram_cen  = !(do_read || wr_go);
   assign sram_gwen = !wr_go;
   assign sram_a    = {{(10-AW){1'b0}}, (do_read ? rd_ptr : wr_ptr)};

   // A returning read word and a bypass word never coincide, so one append slot suffices.
   assign load      = rd_inflight || byp_go;
   assign load_data = rd_inflight ? q : in_data;

   always_comb begin
      // NOTE: every output gets a default first so no path leaves a latch behind.
      ob0_n         = ob0;
      ob1_n         = ob1;
      cnt_after_pop = ob_cnt - {1'b0, pop};
      if (pop) ob0_n = ob1;
      if (load) begin
         if (cnt_after_pop == 2'd0) ob0_n = load_data;
         else                       ob1_n = load_data;
      end
      ob_cnt_n = cnt_after_pop + {1'b0, load};
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (!resetn || flush) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         sram_cnt    <= '0;
         rd_inflight <= 1'b0;
         ob_cnt      <= 2'd0;
         ob0         <= '0;
         ob1         <= '0;
      end else begin
         if (wr_go)   wr_ptr <= wr_ptr + 1'b1;
         if (do_read) rd_ptr <= rd_ptr + 1'b1;
         sram_cnt    <= sram_cnt - SCW'(do_read) + SCW'(wr_go);
         rd_inflight <= do_read;
         ob_cnt      <= ob_cnt_n;
         ob0         <= ob0_n;
         ob1         <= ob1_n;
      end
   end

   for (genvar lane = 0; lane < LANES; lane++) begin : g_lane
      GF_SRAM_512x8_wrapper u_sram (
         .CLK  (clk),
         .CEN  (sram_cen),
         .GWEN (sram_gwen),
         .WEN  (8'h00),
         .A    (sram_a),
         .D    (in_data[lane*8 +: 8]),
         .Q    (q[lane*8 +: 8])
      );
   end

endmodule

// Behavioural model of the GF_SRAM_512x8 wrapper: active-low CEN/GWEN, active-low bit
// write enables, Q registered on a read and held otherwise.
module GF_SRAM_512x8_wrapper (
   input  logic       CLK,
   input  logic       CEN,
   input  logic       GWEN,
   input  logic [7:0] WEN,
   input  logic [9:0] A,
   input  logic [7:0] D,
   output logic [7:0] Q
);

   logic [7:0] mem [1024];

   // NOTE: storage arrays carry no reset; contents are only meaningful once written.
   always_ff @(posedge CLK) begin
      if (!CEN) begin
         if (!GWEN) mem[A] <= (mem[A] & WEN) | (D & ~WEN);
         else       Q      <= mem[A];
      end
   end

endmodule

// File: tb/tb_gf_sram_fifo.sv
// Directed bench for gf_sram_fifo (WIDTH=16, DEPTH=4): reset, bypass, fill/drain,
// random wrap with scoreboard, flush with a read in flight, and backpressure.
module tb_gf_sram_fifo;

   localparam int W  = 16;
   localparam int D  = 4;
   localparam int CW = $clog2(D+3);

   logic          clk = 1'b0;
   logic          resetn, flush, in_valid, in_ready, out_valid, out_ready;
   logic [W-1:0]  in_data, out_data;
   logic [CW-1:0] count;

   int n_checks = 0;
   int n_pass   = 0;
   logic [W-1:0] exp_q [$];

   always #5 clk = ~clk;

   gf_sram_fifo #(.WIDTH(W), .DEPTH(D)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .flush     (flush),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .count     (count)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   // Each cycle starts 1 time unit after the rising edge; inputs settle for 2 more.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic drain(input string tag);
      int budget = 0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      while (exp_q.size() != 0 && budget < 100) begin
         settle();
         if (out_valid) check(tag, 32'(out_data), 32'(exp_q.pop_front()));
         tick();
         budget++;
      end
      if (exp_q.size() != 0) begin
         check({tag, "_timeout"}, exp_q.size(), 0);
         exp_q.delete();
      end
      out_ready = 1'b0;
      check({tag, "_count"}, 32'(count), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int sent;
      int cyc;
      logic [W-1:0] sb [$];

      // Reset with a write request held high.
      resetn    = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b1;
      in_data   = 16'hDEAD;
      out_ready = 1'b0;
      repeat (2) begin
         settle();
         check("rst_in_ready", 32'(in_ready), 0);
         check("rst_cen", 32'(dut.sram_cen), 1);
         tick();
      end
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_count", 32'(count), 0);
      resetn   = 1'b1;
      in_valid = 1'b0;
      tick();

      // Bypass: one word straight into the buffer, SRAM idle.
      in_data  = 16'h00A5;
      in_valid = 1'b1;
      settle();
      check("byp_in_ready", 32'(in_ready), 1);
      check("byp_cen", 32'(dut.sram_cen), 1);
      tick();
      in_valid = 1'b0;
      check("byp_out_valid", 32'(out_valid), 1);
      check("byp_out_data", 32'(out_data), 32'h00A5);
      check("byp_count", 32'(count), 1);
      exp_q.push_back(16'h00A5);
      drain("byp_drain");

      // Fill to capacity DEPTH+2 = 6; the seventh word is refused.
      for (int i = 1; i <= 7; i++) begin
         in_data  = 16'(i);
         in_valid = 1'b1;
         settle();
         check("fill_in_ready", 32'(in_ready), (i <= 6) ? 1 : 0);
         tick();
      end
      in_valid = 1'b0;
      check("fill_count", 32'(count), 6);
      check("fill_head", 32'(out_data), 32'h0001);
      for (int i = 1; i <= 6; i++) exp_q.push_back(16'(i));
      drain("fill_drain");

      // Random push/pop across pointer wrap, checked against a scoreboard.
      sent = 0;
      cyc  = 0;
      while ((sent < 40 || sb.size() != 0) && cyc < 2000) begin
         in_valid  = (sent < 40) && ($urandom_range(0, 1) == 1);
         in_data   = 16'(16'h0100 + sent);
         out_ready = ($urandom_range(0, 1) == 1);
         settle();
         check("wrap_count", 32'(count), sb.size());
         if (count == '0) check("wrap_no_valid", 32'(out_valid), 0);
         if (out_valid && out_ready) begin
            if (sb.size() == 0) check("wrap_underflow", 32'(out_data), 32'hFFFF_FFFF);
            else check("wrap_data", 32'(out_data), 32'(sb.pop_front()));
         end
         if (in_valid && in_ready) begin
            sb.push_back(in_data);
            sent++;
         end
         tick();
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("wrap_sent", sent, 40);
      check("wrap_end_count", 32'(count), 0);

      // Flush while a READ is in flight: the returning word must be discarded.
      for (int i = 1; i <= 3; i++) begin
         in_data  = 16'(16'h0A00 + i);
         in_valid = 1'b1;
         settle();
         check("fl_push_ready", 32'(in_ready), 1);
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      settle();
      check("fl_no_read_full_buf", 32'(dut.sram_cen), 1);
      tick();
      out_ready = 1'b0;
      settle();
      check("fl_read_issued", 32'(dut.sram_cen), 0);
      tick();
      flush = 1'b1;
      settle();
      check("fl_in_ready", 32'(in_ready), 0);
      tick();
      flush = 1'b0;
      check("fl_out_valid", 32'(out_valid), 0);
      check("fl_count", 32'(count), 0);
      tick();
      check("fl_q_discarded", 32'(out_valid), 0);
      in_data  = 16'h0033;
      in_valid = 1'b1;
      settle();
      check("fl_byp_ready", 32'(in_ready), 1);
      tick();
      in_valid = 1'b0;
      check("fl_byp_valid", 32'(out_valid), 1);
      check("fl_byp_data", 32'(out_data), 32'h0033);
      check("fl_byp_count", 32'(count), 1);
      exp_q.push_back(16'h0033);
      drain("fl_drain");

      // Backpressure: head word holds while five more words are accepted.
      in_data  = 16'h0011;
      in_valid = 1'b1;
      settle();
      check("bp_first_ready", 32'(in_ready), 1);
      tick();
      for (int k = 0; k < 5; k++) begin
         in_data  = 16'(16'h0020 + k);
         in_valid = 1'b1;
         settle();
         check("bp_in_ready", 32'(in_ready), 1);
         check("bp_out_valid", 32'(out_valid), 1);
         check("bp_out_data", 32'(out_data), 32'h0011);
         tick();
         check("bp_count", 32'(count), k + 2);
      end
      in_valid = 1'b0;
      exp_q.push_back(16'h0011);
      for (int k = 0; k < 5; k++) exp_q.push_back(16'(16'h0020 + k));
      drain("bp_drain");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
